// File: rtl/note_seq_pkg.sv
// Note sequencer shared definitions: entry layout, note limits, FSM states.
// Optional feature macro: NOTE_SEQ_TRANSPOSE_EN (see note_sequencer.sv).
package note_seq_pkg;

    localparam int ENTRY_W  = 12;
    localparam int NOTE_LSB = 0;
    localparam int NOTE_W   = 6;
    localparam int DUR_LSB  = 6;
    localparam int DUR_W    = 5;
    localparam int LAST_BIT = 11;

    localparam logic [NOTE_W-1:0] NOTE_REST = 6'd63;
    localparam logic [NOTE_W-1:0] NOTE_MAX  = 6'd48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Codes above the top of the tone table collapse onto the top note.
    function automatic logic [NOTE_W-1:0] clamp_note(
        input logic [NOTE_W-1:0] code
    );
        return (code > NOTE_MAX) ? NOTE_MAX : code;
    endfunction

endpackage

// File: rtl/note_seq_if.sv
// Control, table-write and tone-output bundle of the note sequencer.
// NOTE_SEQ_TRANSPOSE_EN adds the signed transpose input.
interface note_seq_if #(
    parameter int DEPTH = 32
);
    import note_seq_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic                start;
    logic                stop;
    logic                loop_en;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [ENTRY_W-1:0]  wr_data;
`ifdef NOTE_SEQ_TRANSPOSE_EN
    logic signed [3:0]   transpose;
`endif
    logic [NOTE_W-1:0]   note;
    logic                gate;
    logic                note_strobe;
    logic                busy;
    logic [AW-1:0]       step_idx;
    logic                done;

    modport master (
`ifdef NOTE_SEQ_TRANSPOSE_EN
        output transpose,
`endif
        output start, stop, loop_en,
        output wr_en, wr_addr, wr_data,
        input  note, gate, note_strobe,
        input  busy, step_idx, done
    );

    modport slave (
`ifdef NOTE_SEQ_TRANSPOSE_EN
        input  transpose,
`endif
        input  start, stop, loop_en,
        input  wr_en, wr_addr, wr_data,
        output note, gate, note_strobe,
        output busy, step_idx, done
    );

endinterface

// File: rtl/note_seq_ram.sv
// Sequence table: single-clock RAM, one write port, registered read.
// Contents survive reset; a colliding read returns the old word.
module note_seq_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and registered read; the read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps through the table, timing each note and gap.
// Macro NOTE_SEQ_TRANSPOSE_EN enables a saturating note transpose.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int DEPTH       = 32
) (
    input logic      clk,
    input logic      resetn,
    note_seq_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam longint CMAX = 32 * longint'(TICK_CYCLES)
                            + longint'(GAP_CYCLES);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    state_t             state, state_n;
    logic [NOTE_W-1:0]  note_q, note_n;
    logic               gate_q, gate_n;
    logic               strobe_q, strobe_n;
    logic               done_q, done_n;
    logic               last_q, last_n;
    logic [AW-1:0]      idx_q, idx_n;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic               advance;

    logic [ENTRY_W-1:0] rd_data;
    logic [NOTE_W-1:0]  code;
    logic [NOTE_W-1:0]  stored;
    logic [NOTE_W-1:0]  emit;
    logic [CW-1:0]      play_load;

    // The RAM always reads the entry that will be current next cycle.
    note_seq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (idx_n),
        .rd_data (rd_data)
    );

    assign code   = rd_data[NOTE_LSB +: NOTE_W];
    assign stored = clamp_note(code);

`ifdef NOTE_SEQ_TRANSPOSE_EN
    logic signed [7:0] shifted;
    assign shifted = signed'({2'b00, stored}) + 8'(bus.transpose);
    assign emit = shifted[7]           ? '0
                : (shifted > 8'sd48)   ? NOTE_MAX
                :                        shifted[NOTE_W-1:0];
`else
    assign emit = stored;
`endif

    assign play_load = CW'(
        (longint'(rd_data[DUR_LSB +: DUR_W]) + 1)
        * longint'(TICK_CYCLES) - 1);

    // Next-state and output logic; stop overrides everything else.
    always_comb begin
        state_n  = state;
        note_n   = note_q;
        gate_n   = gate_q;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        last_n   = last_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        advance  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = FETCH;
                    idx_n   = '0;
                end
            end
            FETCH: begin
                state_n  = PLAY;
                strobe_n = 1'b1;
                last_n   = rd_data[LAST_BIT];
                cnt_n    = play_load;
                if (code == NOTE_REST) begin
                    gate_n = 1'b0;
                end else begin
                    gate_n = 1'b1;
                    note_n = emit;
                end
            end
            PLAY: begin
                if (cnt_q == '0) begin
                    gate_n = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                    end
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_n = cnt_q - CW'(1);
            end
            default: state_n = IDLE;
        endcase
        if (advance) begin
            if (!last_q && idx_q != IDX_LAST) begin
                idx_n   = idx_q + AW'(1);
                state_n = FETCH;
            end else if (bus.loop_en) begin
                idx_n   = '0;
                state_n = FETCH;
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
        if (bus.stop) begin
            state_n  = IDLE;
            gate_n   = 1'b0;
            strobe_n = 1'b0;
            done_n   = 1'b0;
            cnt_n    = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            note_q   <= '0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state    <= state_n;
            note_q   <= note_n;
            gate_q   <= gate_n;
            strobe_q <= strobe_n;
            done_q   <= done_n;
            last_q   <= last_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
        end
    end

    assign bus.note        = note_q;
    assign bus.gate        = gate_q;
    assign bus.note_strobe = strobe_q;
    assign bus.busy        = (state != IDLE);
    assign bus.step_idx    = idx_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (TICK=4, GAP=2, DEPTH=8).
// Transpose checks run only when NOTE_SEQ_TRANSPOSE_EN is defined.
module tb_note_sequencer;

    logic clk;
    logic resetn;

    note_seq_if #(.DEPTH(8)) sb();

    note_sequencer #(
        .TICK_CYCLES (4),
        .GAP_CYCLES  (2),
        .DEPTH       (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       loop_en;
        logic [5:0] note;
        logic       gate;
        logic       strobe;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } vec_t;

    vec_t vec[20];

    int errors = 0;
    int checks = 0;

    logic [5:0] got_note[$];
    logic [2:0] got_idx[$];
    logic       got_gate[$];
    int         done_cyc;
    int         gate_hi;

    function automatic vec_t mk(
        input logic st, sp, lp,
        input logic [5:0] n,
        input logic g, s, b, d,
        input logic [2:0] ix
    );
        vec_t v;
        v.start = st; v.stop = sp; v.loop_en = lp;
        v.note = n; v.gate = g; v.strobe = s;
        v.busy = b; v.done = d; v.idx = ix;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int n,
                      input int d, input bit l);
        sb.wr_en   = 1'b1;
        sb.wr_addr = 3'(a);
        sb.wr_data = {l, 5'(d), 6'(n)};
        tick();
        sb.wr_en   = 1'b0;
    endtask

    task automatic start_pulse();
        sb.start = 1'b1;
        tick();
        sb.start = 1'b0;
    endtask

    // Observe up to max_cyc cycles; stops early on done.
    task automatic collect(input int max_cyc);
        got_note.delete();
        got_idx.delete();
        got_gate.delete();
        done_cyc = -1;
        gate_hi  = 0;
        for (int c = 0; c < max_cyc; c++) begin
            tick();
            if (sb.gate === 1'b1) gate_hi++;
            if (sb.note_strobe === 1'b1) begin
                got_note.push_back(sb.note);
                got_idx.push_back(sb.step_idx);
                got_gate.push_back(sb.gate);
            end
            if (sb.done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    function automatic logic [31:0] nth_note(input int k);
        return (k < got_note.size()) ? 32'(got_note[k]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] nth_idx(input int k);
        return (k < got_idx.size()) ? 32'(got_idx[k]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] nth_gate(input int k);
        return (k < got_gate.size()) ? 32'(got_gate[k]) : 32'hDEAD;
    endfunction

    logic [12:0] act_v;
    logic [12:0] exp_v;
    int          hit;

    initial begin
        sb.start   = 1'b0;
        sb.stop    = 1'b0;
        sb.loop_en = 1'b0;
        sb.wr_en   = 1'b0;
        sb.wr_addr = '0;
        sb.wr_data = '0;
`ifdef NOTE_SEQ_TRANSPOSE_EN
        sb.transpose = 4'sd0;
`endif
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;

        chk("reset_outputs",
            {sb.note, sb.gate, sb.note_strobe,
             sb.busy, sb.done, sb.step_idx}, '0);

        // Two-entry run; start at row 10 lands while busy.
        vec[0] = mk(1, 0, 0,  0, 0, 0, 1, 0, 0);
        vec[1] = mk(0, 0, 0, 28, 1, 1, 1, 0, 0);
        for (int i = 2; i <= 4; i++)
            vec[i] = mk(0, 0, 0, 28, 1, 0, 1, 0, 0);
        for (int i = 5; i <= 6; i++)
            vec[i] = mk(0, 0, 0, 28, 0, 0, 1, 0, 0);
        vec[7] = mk(0, 0, 0, 28, 0, 0, 1, 0, 1);
        vec[8] = mk(0, 0, 0, 30, 1, 1, 1, 0, 1);
        for (int i = 9; i <= 15; i++)
            vec[i] = mk(0, 0, 0, 30, 1, 0, 1, 0, 1);
        vec[10].start = 1'b1;
        for (int i = 16; i <= 17; i++)
            vec[i] = mk(0, 0, 0, 30, 0, 0, 1, 0, 1);
        vec[18] = mk(0, 0, 0, 30, 0, 0, 0, 1, 1);
        vec[19] = mk(0, 0, 0, 30, 0, 0, 0, 0, 1);

        wr(0, 28, 0, 1'b0);
        wr(1, 30, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            sb.start   = vec[i].start;
            sb.stop    = vec[i].stop;
            sb.loop_en = vec[i].loop_en;
            tick();
            act_v = {sb.note, sb.gate, sb.note_strobe,
                     sb.busy, sb.done, sb.step_idx};
            exp_v = {vec[i].note, vec[i].gate, vec[i].strobe,
                     vec[i].busy, vec[i].done, vec[i].idx};
            chk($sformatf("vec_cycle_%0d", i + 1), act_v, exp_v);
        end
        sb.start = 1'b0;

        // Rest entry keeps the previous note and leaves gate low.
        wr(1, 63, 0, 1'b1);
        start_pulse();
        collect(40);
        chk("rest_strobes", got_note.size(), 2);
        chk("rest_note", nth_note(1), 28);
        chk("rest_gate", nth_gate(1), 0);
        chk("rest_gate_hi_cycles", gate_hi, 4);
        chk("rest_done", done_cyc >= 0, 1);
        tick();
        chk("rest_note_after", sb.note, 28);

        // Clamp of out-of-range codes.
        wr(0, 60, 0, 1'b0);
        wr(1, 47, 0, 1'b0);
        wr(2, 49, 0, 1'b0);
        wr(3, 48, 0, 1'b1);
        start_pulse();
        collect(60);
        chk("clamp_60", nth_note(0), 48);
        chk("clamp_47", nth_note(1), 47);
        chk("clamp_49", nth_note(2), 48);
        chk("clamp_48", nth_note(3), 48);

        // Looping two entries, then stop mid-PLAY.
        wr(0, 10, 0, 1'b0);
        wr(1, 12, 0, 1'b1);
        sb.loop_en = 1'b1;
        start_pulse();
        collect(23);
        chk("loop_idx0", nth_idx(0), 0);
        chk("loop_idx1", nth_idx(1), 1);
        chk("loop_idx2", nth_idx(2), 0);
        chk("loop_idx3", nth_idx(3), 1);
        chk("loop_no_done", done_cyc, -1);
        chk("loop_in_play", {sb.gate, sb.busy}, 2'b11);
        sb.stop = 1'b1;
        tick();
        sb.stop    = 1'b0;
        sb.loop_en = 1'b0;
        chk("stop_outputs", {sb.gate, sb.busy, sb.done}, 3'b000);

        // start and stop together from IDLE.
        sb.start = 1'b1;
        sb.stop  = 1'b1;
        tick();
        sb.start = 1'b0;
        sb.stop  = 1'b0;
        chk("start_stop_busy", sb.busy, 0);
        tick();
        chk("start_stop_busy_later", sb.busy, 0);

        // start while playing leaves timing unchanged.
        start_pulse();
        tick();
        chk("busy_first_strobe", {sb.note_strobe, sb.step_idx}, 4'b1000);
        sb.start = 1'b1;
        tick();
        sb.start = 1'b0;
        hit = -1;
        for (int c = 4; c <= 20; c++) begin
            tick();
            if (sb.note_strobe === 1'b1) begin
                hit = c;
                break;
            end
        end
        chk("busy_second_strobe_cycle", hit, 9);
        chk("busy_second_idx", sb.step_idx, 1);
        for (int c = 0; c < 20 && sb.busy; c++) tick();
        chk("busy_ends_idle", sb.busy, 0);

        // Final table slot acts as last even without the bit.
        for (int i = 0; i < 8; i++) wr(i, i + 1, 0, 1'b0);
        start_pulse();
        collect(100);
        chk("bound_count", got_note.size(), 8);
        chk("bound_last_note", nth_note(7), 8);
        chk("bound_last_idx", nth_idx(7), 7);
        chk("bound_done", done_cyc >= 0, 1);

        // Entry 1 rewritten while entry 0 plays.
        wr(0, 20, 1, 1'b0);
        wr(1, 21, 0, 1'b1);
        start_pulse();
        tick();
        wr(1, 33, 0, 1'b1);
        collect(40);
        chk("live_write_note", nth_note(0), 33);
        chk("live_write_count", got_note.size(), 1);

        // Write on the same edge as the read returns old data.
        wr(0, 20, 0, 1'b0);
        wr(1, 22, 0, 1'b1);
        start_pulse();
        for (int c = 2; c <= 7; c++) tick();
        sb.wr_en   = 1'b1;
        sb.wr_addr = 3'd1;
        sb.wr_data = {1'b1, 5'd0, 6'd40};
        tick();
        sb.wr_en = 1'b0;
        tick();
        chk("collide_old", {sb.note_strobe, sb.note}, {1'b1, 6'd22});
        for (int c = 0; c < 20 && sb.busy; c++) tick();
        start_pulse();
        collect(40);
        chk("collide_new_next_run", nth_note(1), 40);

        // Reset during GAP; table survives.
        wr(1, 22, 0, 1'b1);
        start_pulse();
        for (int c = 2; c <= 6; c++) tick();
        chk("in_gap", {sb.gate, sb.busy}, 2'b01);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("reset_mid_gap",
            {sb.note, sb.gate, sb.note_strobe,
             sb.busy, sb.done, sb.step_idx}, '0);
        start_pulse();
        collect(40);
        chk("retained_0", nth_note(0), 20);
        chk("retained_1", nth_note(1), 22);

`ifdef NOTE_SEQ_TRANSPOSE_EN
        wr(0, 45, 0, 1'b1);
        sb.transpose = 4'sd7;
        start_pulse();
        collect(20);
        chk("xpose_up_sat", nth_note(0), 48);
        wr(0, 3, 0, 1'b1);
        sb.transpose = -4'sd8;
        start_pulse();
        collect(20);
        chk("xpose_down_sat", nth_note(0), 0);
        wr(0, 60, 0, 1'b1);
        sb.transpose = 4'sd0;
        start_pulse();
        collect(20);
        chk("xpose_zero_clamp", nth_note(0), 48);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 12_500_000, meaning clk cycles per duration tick (125 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 1_000_000, meaning gate-low articulation cycles after each entry; 0 is legal.
REQ-003 SHALL have parameter DEPTH, default 32, meaning number of sequence entries (power of 2).
REQ-004 SHALL use one clock; reset is synchronous and active-low: port clk, port resetn.
REQ-005 clk  in  1  system clock, 100 MHz.
REQ-006 resetn  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins playback at entry 0.
REQ-008 stop  in  1  one-cycle pulse that aborts playback.
REQ-009 loop_en  in  1  when high, playback restarts at entry 0 after the last entry.
REQ-010 wr_en / wr_addr / wr_data  in  1 / log2(DEPTH) / 12  entry write port; wr_data[5:0] note, [10:6] dur, [11] last.
REQ-011 note  out  6  current note index 0..48 for the tone generator.
REQ-012 gate  out  1  high while a non-rest note sounds.
REQ-013 note_strobe  out  1  one-cycle pulse when note is updated.
REQ-014 busy  out  1  high in any state but IDLE.
REQ-015 step_idx  out  log2(DEPTH)  index of the entry being played.
REQ-016 done  out  1  one-cycle pulse at natural end of a non-looping sequence.

Function
REQ-017 SHALL implement the FSM IDLE -> FETCH -> PLAY -> GAP -> (FETCH | IDLE).
REQ-018 IDLE: start sampled high at cycle N -> FETCH at N+1; step_idx = 0; memory read issued.
REQ-019 FETCH (1 cycle): entry latched; note, gate and note_strobe update at the following edge (first note visible at N+2).
REQ-020 Note code 63 SHALL be a rest: gate = 0, note holds its previous value, note_strobe still pulses.
REQ-021 Note codes 49..62 SHALL be clamped to 48.
REQ-022 PLAY SHALL last exactly (dur+1)*TICK_CYCLES cycles, dur in 0..31.
REQ-023 GAP: gate = 0 for exactly GAP_CYCLES cycles; GAP_CYCLES = 0 SHALL bypass GAP.
REQ-024 At GAP end: last = 0 -> step_idx+1, FETCH; last = 1 and loop_en = 1 -> step_idx = 0, FETCH; last = 1 and loop_en = 0 -> IDLE with done pulse.
REQ-025 step_idx = DEPTH-1 SHALL be treated as last regardless of the last bit (no wrap beyond the table).
REQ-026 stop SHALL force IDLE at the next edge from any state, with gate = 0 and no done pulse.
REQ-027 stop and start in the same cycle: stop SHALL win.
REQ-028 start while busy SHALL be ignored.
REQ-029 Writes SHALL be accepted in any state.
REQ-030 A write and a read to the same address in the same cycle SHALL return the old data.
REQ-031 The loop_en value SHALL be sampled only at the GAP-end decision.
REQ-032 Tick and gap counters SHALL be wide enough for 32*TICK_CYCLES with no overflow.

Reset
REQ-033 resetn low at an edge SHALL give: state IDLE, note = 0, gate = 0, note_strobe = 0, busy = 0, step_idx = 0, done = 0, counters cleared.
REQ-034 Reset SHALL NOT clear memory contents; reset mid-playback SHALL abort identically to stop.

Configuration
REQ-035 Macro NOTE_SEQ_TRANSPOSE_EN defined: adds input transpose (4-bit signed); the emitted note is stored note + transpose, saturated to 0..48; rests are unaffected; transpose is sampled in FETCH.
REQ-036 Macro undefined: no transpose port; the stored note is emitted unchanged (after the REQ-021 clamp).

Structure
REQ-037 Package note_seq_pkg SHALL hold entry field positions and widths, NOTE_REST = 63, NOTE_MAX = 48, and the FSM state encoding.
REQ-038 Sub-module note_seq_ram SHALL hold a DEPTH x 12 single-clock RAM with synchronous read and one write port; no reset.

Verification (TICK_CYCLES = 4, GAP_CYCLES = 2)
REQ-039 Entries {28, dur 0}, {30, dur 1, last}, start at cycle 0 -> note_strobe at 2 with note 28; gate high for 4 cycles, low for 2; note 30 with gate high for 8 cycles; done pulse; busy falls.
REQ-040 Entry {63, dur 0, last} after a note 28 -> gate stays 0 and note stays 28 through the rest; note_strobe pulses.
REQ-041 loop_en = 1 with 2 entries -> step_idx sequence 0, 1, 0, 1; no done; stop mid-PLAY -> gate = 0 and busy = 0 one cycle later.
REQ-042 start and stop in the same cycle from IDLE -> stays IDLE; start while busy -> step_idx timing unchanged.
REQ-043 NOTE_SEQ_TRANSPOSE_EN defined, transpose = +7, note 45 -> 48; transpose = -8, note 3 -> 0; note 60 with transpose 0 -> 48.
REQ-044 Write entry 1 while entry 0 plays -> the new entry 1 is played; resetn low mid-GAP -> all outputs at reset values, memory contents retained.
